// File: rtl/pwm_mon_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pwm_mon_pkg
// Description : Shared helpers for the popcount window monitor: width sizing
//               and a width-argument popcount usable at any vector size.
// Revision    : 1.0 - initial release
// ============================================================================
package pwm_mon_pkg;

    // Widest vector the popcount helper accepts; callers zero-extend into it.
    localparam int unsigned PC_MAX_W = 256;

    function automatic int unsigned cnt_width(input int unsigned n);
        int unsigned w;
        w = $clog2(n + 1);
        return (w < 1) ? 1 : w;
    endfunction

    function automatic int unsigned popcount(input logic [PC_MAX_W-1:0] v,
                                             input int unsigned        w);
        int unsigned c;
        c = 0;
        for (int unsigned i = 0; i < PC_MAX_W; i++) begin
            if ((i < w) && v[i]) begin
                c = c + 1;
            end
        end
        return c;
    endfunction

endpackage : pwm_mon_pkg
`default_nettype wire

// File: rtl/popcount_window_monitor_filter.sv
`default_nettype none
// ============================================================================
// Module      : stable_filter
// Description : Persistence filter; q_out follows d only after d has differed
//               from q_out for HOLD consecutive cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module stable_filter #(
    parameter int   HOLD    = 4,
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q_out
);

    localparam int c_hold_w = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [c_hold_w-1:0] c_hold_last = c_hold_w'(HOLD - 1);

    generate
        if (HOLD < 1) begin : g_bad_hold
            $fatal(1, "stable_filter: HOLD must be >= 1");
        end
    endgenerate

    logic [c_hold_w-1:0] r_hold_cnt;
    logic                r_q;

    // Any agreeing cycle restarts the run, so only an unbroken disagreement moves r_q.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold_cnt <= '0;
            r_q        <= RST_VAL;
        end else if (d == r_q) begin
            r_hold_cnt <= '0;
        end else if (r_hold_cnt == c_hold_last) begin
            r_q        <= d;
            r_hold_cnt <= '0;
        end else begin
            r_hold_cnt <= r_hold_cnt + c_hold_w'(1);
        end
    end

    assign q_out = r_q;

endmodule : stable_filter
`default_nettype wire

// File: rtl/popcount_window_monitor.sv
`default_nettype none
// ============================================================================
// Module      : popcount_window_monitor
// Description : Flags when at most MAX_ACTIVE of N registered inputs are high,
//               with glitch filter, sticky violation flag and blinking LED.
// Revision    : 1.0 - initial release
// ============================================================================
module popcount_window_monitor
    import pwm_mon_pkg::*;
#(
    parameter  int N          = 3,
    parameter  int MAX_ACTIVE = 1,
    parameter  int HOLD       = 4,
    parameter  int BLINK_DIV  = 8,
    localparam int CNT_W      = cnt_width(N)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     in_vec,
    input  logic             clr,
    output logic [CNT_W-1:0] count,
    output logic             q,
    output logic             q_stable,
    output logic             viol_sticky,
    output logic             led
);

    localparam int unsigned c_max_active = MAX_ACTIVE;
    localparam int          c_blink_w    = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [c_blink_w-1:0] c_blink_last = c_blink_w'(BLINK_DIV - 1);

    generate
        if (N < 1 || N > int'(PC_MAX_W)) begin : g_bad_n
            $fatal(1, "popcount_window_monitor: N out of range");
        end
        if (MAX_ACTIVE < 0 || MAX_ACTIVE > N) begin : g_bad_max
            $fatal(1, "popcount_window_monitor: MAX_ACTIVE must be in 0..N");
        end
        if (BLINK_DIV < 1) begin : g_bad_blink
            $fatal(1, "popcount_window_monitor: BLINK_DIV must be >= 1");
        end
    endgenerate

    logic [N-1:0]         r_in;
    logic [CNT_W-1:0]     r_count;
    logic                 r_q;
    logic                 r_viol;
    logic [c_blink_w-1:0] r_blink_cnt;
    logic                 r_blink_phase;
    logic                 r_led;
    logic                 w_q_stable;
    int unsigned          w_pop;

    assign w_pop = popcount(PC_MAX_W'(r_in), N);

    // Inputs are asynchronous to clk, so they are registered once before counting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_in    <= '0;
            r_count <= '0;
            r_q     <= 1'b1;
        end else begin
            r_in    <= in_vec;
            r_count <= CNT_W'(w_pop);
            r_q     <= (w_pop <= c_max_active);
        end
    end

    stable_filter #(
        .HOLD    (HOLD),
        .RST_VAL (1'b1)
    ) u_filter (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (r_q),
        .q_out (w_q_stable)
    );

    // Set has priority, so clr cannot drop the flag while the violation persists.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_viol <= 1'b0;
        end else if (!w_q_stable) begin
            r_viol <= 1'b1;
        end else if (clr) begin
            r_viol <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_blink_cnt   <= '0;
            r_blink_phase <= 1'b0;
        end else if (!r_viol) begin
            r_blink_cnt   <= '0;
            r_blink_phase <= 1'b0;
        end else if (r_blink_cnt == c_blink_last) begin
            r_blink_cnt   <= '0;
            r_blink_phase <= ~r_blink_phase;
        end else begin
            r_blink_cnt   <= r_blink_cnt + c_blink_w'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_led <= 1'b1;
        end else begin
            r_led <= r_viol ? r_blink_phase : w_q_stable;
        end
    end

    assign count       = r_count;
    assign q           = r_q;
    assign q_stable    = w_q_stable;
    assign viol_sticky = r_viol;
    assign led         = r_led;

endmodule : popcount_window_monitor
`default_nettype wire

// File: doc/popcount_window_monitor.md
Name: popcount_window_monitor

Overview:
Parametrised successor to the 3-input "at most one active" detector. Monitors an N-bit input vector and flags when no more than MAX_ACTIVE bits are high. It adds registered inputs, a live count output, a persistence filter against glitches, a sticky violation flag with software clear, and a blinking LED drive. It sits between raw switch/sensor inputs and the board LED.

Parameters:
N, 3, input vector width; must be >= 1.
MAX_ACTIVE, 1, largest number of active bits that still counts as OK; must be in 0..N.
HOLD, 4, consecutive cycles q must disagree with q_stable before q_stable follows it; must be >= 1.
BLINK_DIV, 8, cycles per LED half-period while a violation is latched; must be >= 1.

Ports:
clk  input  1  single clock; all state changes on the rising edge.
rst_n  input  1  asynchronous, active-low reset.
in_vec  input  N  raw monitored inputs; asynchronous to the logic, so they are registered once on entry.
clr  input  1  clears the sticky violation flag; level-sensitive and sampled every cycle.
count  output  CNT_W  number of 1s in the registered input; CNT_W = $clog2(N+1), with a minimum of 1.
q  output  1  unfiltered OK flag: 1 when count <= MAX_ACTIVE.
q_stable  output  1  persistence-filtered version of q.
viol_sticky  output  1  latched violation flag.
led  output  1  LED drive.

Behaviour:
- Reset (rst_n low): asynchronous, takes effect immediately, including mid-operation. Reset values:
  - in_r = 0, count = 0, q = 1, q_stable = 1
  - hold_cnt = 0, viol_sticky = 0
  - blink_cnt = 0, blink_phase = 0, led = 1
- Stage 1: in_r <= in_vec.
- Stage 2:
  - count <= popcount(in_r), computed at full CNT_W width with no overflow.
  - q <= (popcount(in_r) <= MAX_ACTIVE).
  - Latency from in_vec to count/q is 2 cycles.
- Persistence filter:
  - If q == q_stable: hold_cnt <= 0.
  - Else if hold_cnt == HOLD-1: q_stable <= q and hold_cnt <= 0.
  - Else: hold_cnt <= hold_cnt + 1.
  - Net effect: q_stable changes only after q has differed for HOLD consecutive cycles. Any agreeing cycle restarts the count.
  - With HOLD=1, q_stable is q delayed by 1 cycle.
- Sticky flag, next-state priority:
  - q_stable == 0: viol_sticky <= 1. Set wins over clr.
  - Else if clr: viol_sticky <= 0.
  - Else: hold.
  - Consequence: clr is ignored while the violation persists.
- Blink generator:
  - While viol_sticky == 0: blink_cnt <= 0, blink_phase <= 0.
  - While viol_sticky == 1: blink_cnt increments. At BLINK_DIV-1 it wraps to 0 and blink_phase toggles.
- LED: led <= viol_sticky ? blink_phase : q_stable.
  - The LED goes off on the first cycle after viol_sticky sets.
  - It then toggles every BLINK_DIV cycles.
- Timing chain from q falling (at cycle t, filter running):
  - q_stable falls at t+HOLD.
  - viol_sticky rises at t+HOLD+1.
  - led = 0 at t+HOLD+2.
- Edge cases:
  - MAX_ACTIVE = N: q is constant 1.
  - MAX_ACTIVE = 0: q = 1 only when all inputs are 0.
  - N = 1: count is 1 bit wide.
  - Counters never exceed HOLD-1 or BLINK_DIV-1.
- Parameter legality is checked at elaboration. An illegal value is a fatal error.

Decomposition:
- Shared package pwm_mon_pkg holds:
  - function popcount(logic [N-1:0]), parametrised through its width argument;
  - function cnt_width(n), which returns max(1, $clog2(n+1)).
- Sub-module stable_filter #(HOLD) with ports clk, rst_n, d, q_out.
  - Reset value of q_out is a parameter (RST_VAL, default 1).
  - Reused later for other debounced board inputs.

Test Plan:
1. Reset: drive in_vec = 3'b111 until q_stable = 0 and led is blinking, then pulse rst_n low for 1 ns between edges. All outputs must return to their reset values immediately, without waiting for a clock edge.
2. Truth-table sweep (defaults): hold each of the 8 vectors for 10 cycles.
   - count = number of 1s.
   - q = 1 only for 000, 001, 010, 100, each appearing 2 cycles after the input is applied.
   - Transitions between OK vectors never move q_stable.
3. Glitch rejection: from 000, apply 011 for 3 cycles, then 000. q must pulse 0 for 3 cycles while q_stable stays 1 and viol_sticky stays 0. Repeat with 4 cycles: q_stable must fall 4 cycles after q falls, and viol_sticky must rise 1 cycle later.
4. Blink: hold 111 for 40 cycles. Once viol_sticky = 1, led must be 0 for 8 cycles, then 1 for 8 cycles, alternating.
5. Clear rules:
   - Assert clr while 111 is present: viol_sticky must stay 1.
   - Apply 000 and wait until q_stable = 1 (2+4 cycles); led must still blink.
   - Pulse clr for 1 cycle: viol_sticky = 0 on the next edge, blink_cnt = 0, and led = 1 one cycle after that.
6. Generality (N = 8, MAX_ACTIVE = 2, HOLD = 1):
   - in_vec = 8'h81 → count = 2, q = 1.
   - in_vec = 8'h07 → count = 3, q = 0, with q_stable = 0 one cycle after q.
   - in_vec = 8'hFF → count = 8, proving CNT_W = 4.
